// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS front end: next-PC selects, instruction field
// positions, fetch FSM states and the default reset vector.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    // Next-PC select encodings driven by the main control decoder
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JR  = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    // Instruction field bit positions
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned JIDX_MSB  = 25;
    localparam int unsigned JIDX_LSB  = 0;

    // Width of the ack-timeout counter (timeouts up to 255 cycles)
    localparam int unsigned TO_W = 8;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_RETRY = 2'b10,
        S_EXEC  = 2'b11
    } fetch_state_t;

endpackage : mips_pkg

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, jr, branch and jump targets.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]     i_pc,
    input  logic [JIDX_MSB:0]   i_inst_lo,
    input  logic [1:0]          i_pc_s,
    input  logic [XLEN-1:0]     i_rs_data,
    output logic [XLEN-1:0]     o_pc_plus4_c,
    output logic [XLEN-1:0]     o_next_pc_c,
    output logic                o_misalign_c
);

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_off;
    logic [15:0]     w_imm;

    assign w_pc_plus4   = i_pc + 32'd4;
    assign w_imm        = i_inst_lo[IMM_MSB:IMM_LSB];
    // Sign-extended immediate, already scaled to a byte offset
    assign w_br_off     = {{14{w_imm[15]}}, w_imm, 2'b00};
    assign o_pc_plus4_c = w_pc_plus4;

    // Target mux; only a jr can produce a misaligned target
    always_comb begin
        o_next_pc_c  = w_pc_plus4;
        o_misalign_c = 1'b0;
        case (i_pc_s)
            PC_SEQ: o_next_pc_c = w_pc_plus4;
            PC_JR: begin
                o_next_pc_c  = {i_rs_data[XLEN-1:2], 2'b00};
                o_misalign_c = |i_rs_data[1:0];
            end
            PC_BR:  o_next_pc_c = w_pc_plus4 + w_br_off;
            PC_J:   o_next_pc_c = {w_pc_plus4[31:28], i_inst_lo[JIDX_MSB:JIDX_LSB], 2'b00};
            default: o_next_pc_c = w_pc_plus4;
        endcase
    end

endmodule : next_pc_calc

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, imem req/ack fetch FSM with
// timeout/retry, instruction latch and field split, retirement counter.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned ACK_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PC_s,
    input  logic [31:0] rs_data,
    input  logic        exec_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [5:0]  op_code,
    output logic [5:0]  funct,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [15:0] imm,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic [31:0] inst_cnt,
    output logic        align_err,
    output logic        fetch_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [31:0]     r_pc;
    logic [31:0]     r_inst;
    logic [31:0]     r_inst_cnt;
    logic            r_inst_valid;
    logic            r_imem_req;
    logic            r_align_err;
    logic            r_fetch_err;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            w_ack_take;
    logic            w_retire;
    logic            w_timeout;
    logic [31:0]     w_next_pc;
    logic [31:0]     w_pc_plus4;
    logic            w_misalign;

    next_pc_calc u_next_pc_calc (
        .i_pc         (r_pc),
        .i_inst_lo    (r_inst[JIDX_MSB:0]),
        .i_pc_s       (PC_s),
        .i_rs_data    (rs_data),
        .o_pc_plus4_c (w_pc_plus4),
        .o_next_pc_c  (w_next_pc),
        .o_misalign_c (w_misalign)
    );

    // Next-state and per-cycle event decode for the fetch FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_ack_take   = 1'b0;
        w_retire     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt  = S_FETCH;
                w_to_cnt_nxt = '0;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_nxt  = S_EXEC;
                    w_to_cnt_nxt = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_nxt  = S_RETRY;
                    w_to_cnt_nxt = '0;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_RETRY: begin
                w_state_nxt  = S_FETCH;
                w_to_cnt_nxt = '0;
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_to_cnt_nxt = '0;
            end
        endcase
    end

    // State, PC, instruction latch and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_to_cnt     <= '0;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b0;
            r_inst_cnt   <= '0;
            r_align_err  <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_imem_req <= (w_state_nxt == S_FETCH);
            if (w_ack_take) begin
                r_inst       <= imem_rdata;
                r_inst_valid <= 1'b1;
            end
            if (w_retire) begin
                r_pc         <= w_next_pc;
                r_inst_cnt   <= r_inst_cnt + 32'd1;
                r_inst_valid <= 1'b0;
                if (w_misalign) begin
                    r_align_err <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign op_code    = r_inst[OP_MSB:OP_LSB];
    assign funct      = r_inst[FUNCT_MSB:FUNCT_LSB];
    assign rs_addr    = r_inst[RS_MSB:RS_LSB];
    assign rt_addr    = r_inst[RT_MSB:RT_LSB];
    assign rd_addr    = r_inst[RD_MSB:RD_LSB];
    assign imm        = r_inst[IMM_MSB:IMM_LSB];
    assign PC         = r_pc;
    assign PC_plus4   = w_pc_plus4;
    assign inst_cnt   = r_inst_cnt;
    assign align_err  = r_align_err;
    assign fetch_err  = r_fetch_err;

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with hand-computed expected values.
module tb_inst_fetch_unit;

    localparam int unsigned TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  PC_s = 2'b00;
    logic [31:0] rs_data = '0;
    logic        exec_done = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  op_code;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [15:0] imm;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic [31:0] inst_cnt;
    logic        align_err;
    logic        fetch_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_cnt = '0;

    inst_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PC_s       (PC_s),
        .rs_data    (rs_data),
        .exec_done  (exec_done),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .inst_valid (inst_valid),
        .inst       (inst),
        .op_code    (op_code),
        .funct      (funct),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .imm        (imm),
        .PC         (PC),
        .PC_plus4   (PC_plus4),
        .inst_cnt   (inst_cnt),
        .align_err  (align_err),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request, hold off for lat cycles, then ack with word
    task automatic fetch_ack(input logic [31:0] exp_addr, input logic [31:0] word, input int lat);
        bit seen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("req_seen", 32'(seen), 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        @(negedge clk);
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, word);
    endtask

    // Retire the current instruction with the given next-PC select
    task automatic exec(input logic [1:0] sel, input logic [31:0] rs);
        PC_s      = sel;
        rs_data   = rs;
        exec_done = 1'b1;
        @(posedge clk);
        #1 exec_done = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_cnt", inst_cnt, 32'd0);
        chk("rst_errs", {30'd0, align_err, fetch_err}, 32'd0);
        rst = 1'b1;

        // First fetch, acked on the first request cycle: addi $t0,$zero,5
        fetch_ack(32'h0, 32'h2008_0005, 0);
        chk("op_code", 32'(op_code), 32'h08);
        chk("rt_addr", 32'(rt_addr), 32'd8);
        chk("rs_addr", 32'(rs_addr), 32'd0);
        chk("imm", 32'(imm), 32'h0005);
        chk("funct", 32'(funct), 32'h05);
        chk("pc_plus4", PC_plus4, 32'h4);

        // jr to 0x10, then sequential from 0x10
        exec(2'b01, 32'h0000_0010);
        fetch_ack(32'h0000_0010, 32'h0000_0000, 0);
        chk("cnt_1", inst_cnt, exp_cnt);
        exec(2'b00, 32'h0);
        fetch_ack(32'h0000_0014, 32'h0000_0000, 0);
        chk("cnt_2", inst_cnt, exp_cnt);

        // Backward branch from 0x20 with imm=0xFFFE
        exec(2'b01, 32'h0000_0020);
        fetch_ack(32'h0000_0020, 32'h1000_FFFE, 0);
        chk("br_imm", 32'(imm), 32'h0000_FFFE);
        exec(2'b10, 32'h0);
        fetch_ack(32'h0000_001C, 32'h0000_0000, 0);

        // Forward branch from 0x20 with imm=0x0003
        exec(2'b01, 32'h0000_0020);
        fetch_ack(32'h0000_0020, 32'h1000_0003, 0);
        exec(2'b10, 32'h0);
        fetch_ack(32'h0000_0030, 32'h0000_0000, 0);

        // j index 0x100 from 0x4000_0000
        exec(2'b01, 32'h4000_0000);
        fetch_ack(32'h4000_0000, 32'h0800_0100, 1);
        chk("j_op", 32'(op_code), 32'h02);
        exec(2'b11, 32'h0);
        fetch_ack(32'h4000_0400, 32'h0000_0000, 0);
        chk("align_pre", 32'(align_err), 32'd0);

        // Misaligned jr target is truncated and flags align_err (sticky)
        exec(2'b01, 32'h0000_1003);
        fetch_ack(32'h0000_1000, 32'h0000_0000, 0);
        chk("align_set", 32'(align_err), 32'd1);
        exec(2'b00, 32'h0);

        // Withhold ack for the full timeout window at 0x1004
        @(negedge clk);
        chk("to_req", 32'(imem_req), 32'd1);
        chk("to_addr", imem_addr, 32'h0000_1004);
        repeat (TB_TIMEOUT - 1) @(negedge clk);
        chk("to_last_req", 32'(imem_req), 32'd1);
        chk("to_last_err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        chk("retry_req", 32'(imem_req), 32'd0);
        chk("fetch_err", 32'(fetch_err), 32'd1);
        fetch_ack(32'h0000_1004, 32'h0000_0000, 3);
        chk("align_sticky", 32'(align_err), 32'd1);
        chk("ferr_sticky", 32'(fetch_err), 32'd1);

        // PC wrap at the top of the address space
        exec(2'b01, 32'hFFFF_FFFC);
        fetch_ack(32'hFFFF_FFFC, 32'h0000_0000, 0);
        chk("wrap_p4", PC_plus4, 32'h0000_0000);
        exec(2'b00, 32'h0);

        // exec_done during a fetch is ignored
        @(negedge clk);
        PC_s      = 2'b01;
        rs_data   = 32'h0000_0100;
        exec_done = 1'b1;
        @(posedge clk);
        #1 exec_done = 1'b0;
        @(negedge clk);
        chk("ign_pc", PC, 32'h0000_0000);
        chk("ign_cnt", inst_cnt, exp_cnt);
        fetch_ack(32'h0000_0000, 32'h0000_0000, 0);
        exec(2'b00, 32'h0);

        // Reset while fetching at 0x4 with a simultaneous ack
        @(negedge clk);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        chk("pre_rst_addr", imem_addr, 32'h0000_0004);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_cnt", inst_cnt, 32'd0);
        chk("mid_rst_errs", {30'd0, align_err, fetch_err}, 32'd0);
        exp_cnt = '0;
        // Ack still high through the idle cycle must be ignored
        rst = 1'b1;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_valid", 32'(inst_valid), 32'd0);
        chk("idle_ack_inst", inst, 32'h0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        fetch_ack(32'h0000_0000, 32'h2008_0005, 0);
        chk("post_rst_op", 32'(op_code), 32'h08);
        exec(2'b00, 32'h0);
        @(negedge clk);
        chk("post_rst_cnt", inst_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_inst_fetch_unit
